// File: rtl/rdmx_xmit_mux.sv
// rdmx_xmit_mux: N-channel RDMX transmit back-end.
// Round-robin picks one (plen, addr) pair. It builds a 64-byte Ethernet/IPv4/UDP/RDMX
// header beat, then passes the granted channel's data beats through to AXIS_TX.
// Optional feature macro: RDMX_SEQNUM_EN. When it is defined, each channel keeps a
// 32-bit sequence counter, written into header bytes 52..55.
module rdmx_xmit_mux #(
   parameter int NUM_CH             = 4,
   parameter int DATA_WBITS         = 512,
   parameter int ADDR_WBITS         = 64,
   parameter int SRC_MAC            = 2,
   parameter int SRC_IP0            = 10,
   parameter int SRC_IP1            = 1,
   parameter int SRC_IP2            = 1,
   parameter int SRC_IP3            = 2,
   parameter int DST_IP0            = 10,
   parameter int DST_IP1            = 1,
   parameter int DST_IP2            = 1,
   parameter int DST_IP3            = 255,
   parameter int SOURCE_PORT        = 1000,
   parameter int REMOTE_SERVER_PORT = 32002
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [16*NUM_CH-1:0]         AXIS_PLEN_TDATA,
   input  logic [NUM_CH-1:0]            AXIS_PLEN_TVALID,
   output logic [NUM_CH-1:0]            AXIS_PLEN_TREADY,
   input  logic [ADDR_WBITS*NUM_CH-1:0] AXIS_ADDR_TDATA,
   input  logic [NUM_CH-1:0]            AXIS_ADDR_TVALID,
   output logic [NUM_CH-1:0]            AXIS_ADDR_TREADY,
   input  logic [DATA_WBITS*NUM_CH-1:0] AXIS_DATA_TDATA,
   input  logic [NUM_CH-1:0]            AXIS_DATA_TLAST,
   input  logic [NUM_CH-1:0]            AXIS_DATA_TVALID,
   output logic [NUM_CH-1:0]            AXIS_DATA_TREADY,
   output logic [DATA_WBITS-1:0]        AXIS_TX_TDATA,
   output logic [DATA_WBITS/8-1:0]      AXIS_TX_TKEEP,
   output logic                         AXIS_TX_TLAST,
   output logic                         AXIS_TX_TVALID,
   input  logic                         AXIS_TX_TREADY,
   output logic [2:0]                   active_ch
);

   localparam int KW = DATA_WBITS / 8;
   localparam logic [15:0] SIP_HI = {8'(SRC_IP0), 8'(SRC_IP1)};
   localparam logic [15:0] SIP_LO = {8'(SRC_IP2), 8'(SRC_IP3)};
   localparam logic [15:0] DIP_HI = {8'(DST_IP0), 8'(DST_IP1)};
   localparam logic [15:0] DIP_LO = {8'(DST_IP2), 8'(DST_IP3)};

   typedef enum logic [1:0] {ST_IDLE, ST_CSUM, ST_HDR, ST_DATA} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             ptr_q, ptr_d;
   logic [2:0]             ch_q, ch_d;
   logic [15:0]            plen_q, plen_d;
   logic [63:0]            addr_q, addr_d;
   logic [DATA_WBITS-1:0]  hdr_q, hdr_d;

   logic [NUM_CH-1:0]      cand_s;
   logic [NUM_CH-1:0]      gnt_oh_s;
   logic                   gnt_found_s;
   logic                   gnt_hit_s;
   logic [2:0]             gnt_idx_s;
   logic [15:0]            g_plen_s;
   logic [63:0]            g_addr_s;
   logic                   d_valid_s;
   logic                   d_last_s;
   logic [DATA_WBITS-1:0]  d_data_s;
   logic [KW-1:0]          last_keep_s;
   logic [31:0]            seq_cur_s;

   // IPv4 header checksum. Constant words are folded in here; only total length varies.
   function automatic logic [15:0] ip_csum(input logic [15:0] tot_len);
      logic [31:0] s;
      s = 32'h0000_4500 + {16'h0000, tot_len} + 32'h0000_4000 + 32'h0000_4011
        + {16'h0000, SIP_HI} + {16'h0000, SIP_LO} + {16'h0000, DIP_HI} + {16'h0000, DIP_LO};
      s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
      s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
      return ~s[15:0];
   endfunction

   // Assemble the 64-byte header. Byte i lands in bits [8i+7:8i], and all fields are big-endian.
   function automatic logic [DATA_WBITS-1:0] build_hdr(input logic [15:0] plen,
                                                        input logic [63:0] addr,
                                                        input logic [15:0] dport,
                                                        input logic [31:0] seq);
      logic [7:0]            hb [64];
      logic [15:0]           tot_len;
      logic [15:0]           udp_len;
      logic [15:0]           csum;
      logic [DATA_WBITS-1:0] h;
      tot_len = plen + 16'd50;
      udp_len = plen + 16'd30;
      csum    = ip_csum(tot_len);
      for (int i = 0; i < 64; i++) hb[i] = 8'h00;
      for (int i = 0; i < 6; i++) hb[i] = 8'hFF;
      hb[6]  = 8'h02;
      hb[11] = 8'(SRC_MAC);
      hb[12] = 8'h08;
      hb[14] = 8'h45;
      hb[16] = tot_len[15:8];
      hb[17] = tot_len[7:0];
      hb[20] = 8'h40;
      hb[22] = 8'h40;
      hb[23] = 8'h11;
      hb[24] = csum[15:8];
      hb[25] = csum[7:0];
      hb[26] = SIP_HI[15:8];
      hb[27] = SIP_HI[7:0];
      hb[28] = SIP_LO[15:8];
      hb[29] = SIP_LO[7:0];
      hb[30] = DIP_HI[15:8];
      hb[31] = DIP_HI[7:0];
      hb[32] = DIP_LO[15:8];
      hb[33] = DIP_LO[7:0];
      hb[34] = 8'(SOURCE_PORT >> 8);
      hb[35] = 8'(SOURCE_PORT);
      hb[36] = dport[15:8];
      hb[37] = dport[7:0];
      hb[38] = udp_len[15:8];
      hb[39] = udp_len[7:0];
      hb[42] = 8'h01;
      hb[43] = 8'h22;
      for (int i = 0; i < 8; i++) hb[44+i] = addr[63-8*i -: 8];
      for (int i = 0; i < 4; i++) hb[52+i] = seq[31-8*i -: 8];
      h = '0;
      for (int i = 0; i < 64; i++) h[8*i +: 8] = hb[i];
      return h;
   endfunction

`ifdef RDMX_SEQNUM_EN
   logic [31:0] seq_q [NUM_CH];
   logic        seq_inc_s;

   // The sequence number advances when the header beat is accepted.
   assign seq_inc_s = (state_q == ST_HDR) && AXIS_TX_TREADY && !reset;

   // Select the granted channel's counter for the header under construction.
   always_comb begin
      seq_cur_s = 32'd0;
      for (int k = 0; k < NUM_CH; k++)
         seq_cur_s = seq_cur_s | (seq_q[k] & {32{ch_q == 3'(k)}});
   end

   // Per-channel sequence counters. They wrap naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) seq_q[k] <= 32'd0;
      end else begin
         for (int k = 0; k < NUM_CH; k++)
            if (seq_inc_s && (ch_q == 3'(k))) seq_q[k] <= seq_q[k] + 32'd1;
      end
   end
`else
   assign seq_cur_s = 32'd0;
`endif

   // Round-robin search from the channel after the last grant, then mux out the winner's plen and addr.
   always_comb begin
      cand_s      = AXIS_PLEN_TVALID & AXIS_ADDR_TVALID;
      gnt_found_s = 1'b0;
      gnt_hit_s   = 1'b0;
      gnt_idx_s   = 3'd0;
      gnt_oh_s    = '0;
      g_plen_s    = 16'd0;
      g_addr_s    = 64'd0;
      for (int i = 1; i <= NUM_CH; i++) begin
         for (int k = 0; k < NUM_CH; k++) begin
            gnt_hit_s   = !gnt_found_s && cand_s[k] && (((int'(ptr_q) + i) % NUM_CH) == k);
            gnt_idx_s   = gnt_hit_s ? 3'(k) : gnt_idx_s;
            gnt_found_s = gnt_found_s | gnt_hit_s;
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         gnt_oh_s[k] = gnt_found_s && (gnt_idx_s == 3'(k));
         g_plen_s    = g_plen_s | (AXIS_PLEN_TDATA[16*k +: 16] & {16{gnt_oh_s[k]}});
         g_addr_s    = g_addr_s | (64'(AXIS_ADDR_TDATA[ADDR_WBITS*k +: ADDR_WBITS]) & {64{gnt_oh_s[k]}});
      end
   end

   // Mux the active channel's data stream, and form the keep mask for the final data beat.
   always_comb begin
      d_valid_s = 1'b0;
      d_last_s  = 1'b0;
      d_data_s  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         d_valid_s = d_valid_s | (AXIS_DATA_TVALID[k] & (ch_q == 3'(k)));
         d_last_s  = d_last_s  | (AXIS_DATA_TLAST[k]  & (ch_q == 3'(k)));
         d_data_s  = d_data_s  | (AXIS_DATA_TDATA[DATA_WBITS*k +: DATA_WBITS] & {DATA_WBITS{ch_q == 3'(k)}});
      end
      last_keep_s = (plen_q[5:0] == 6'd0) ? {KW{1'b1}} : ((KW'(1) << plen_q[5:0]) - KW'(1));
   end

   // Next-state logic and stream outputs. While reset is high, every output is held at zero.
   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      ch_d             = ch_q;
      plen_d           = plen_q;
      addr_d           = addr_q;
      hdr_d            = hdr_q;
      AXIS_PLEN_TREADY = '0;
      AXIS_ADDR_TREADY = '0;
      AXIS_DATA_TREADY = '0;
      AXIS_TX_TDATA    = '0;
      AXIS_TX_TKEEP    = '0;
      AXIS_TX_TLAST    = 1'b0;
      AXIS_TX_TVALID   = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_found_s) begin
                  AXIS_PLEN_TREADY = gnt_oh_s;
                  AXIS_ADDR_TREADY = gnt_oh_s;
                  plen_d  = g_plen_s;
                  addr_d  = g_addr_s;
                  ch_d    = gnt_idx_s;
                  ptr_d   = gnt_idx_s;
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CSUM: begin
               hdr_d   = build_hdr(plen_q, addr_q, 16'(REMOTE_SERVER_PORT) + {13'd0, ch_q}, seq_cur_s);
               state_d = ST_HDR;
            end
            ST_HDR: begin
               AXIS_TX_TVALID = 1'b1;
               AXIS_TX_TDATA  = hdr_q;
               AXIS_TX_TKEEP  = {KW{1'b1}};
               AXIS_TX_TLAST  = (plen_q == 16'd0);
               if (AXIS_TX_TREADY) begin
                  state_d = (plen_q == 16'd0) ? ST_IDLE : ST_DATA;
               end else begin
                  state_d = ST_HDR;
               end
            end
            ST_DATA: begin
               AXIS_TX_TVALID = d_valid_s;
               AXIS_TX_TDATA  = d_data_s;
               AXIS_TX_TLAST  = d_last_s;
               AXIS_TX_TKEEP  = d_last_s ? last_keep_s : {KW{1'b1}};
               for (int k = 0; k < NUM_CH; k++)
                  AXIS_DATA_TREADY[k] = AXIS_TX_TREADY & (ch_q == 3'(k));
               if (d_valid_s && AXIS_TX_TREADY && d_last_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = ST_IDLE;
      end
   end

   // State and packet-context registers. Reset drops any in-flight packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 3'd0;
         ch_q    <= 3'd0;
         plen_q  <= 16'd0;
         addr_q  <= 64'd0;
         hdr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ch_q    <= ch_d;
         plen_q  <= plen_d;
         addr_q  <= addr_d;
         hdr_q   <= hdr_d;
      end
   end

   assign active_ch = ch_q;

endmodule

// File: tb/tb_rdmx_xmit_mux.sv
// Scoreboard bench for rdmx_xmit_mux: directed packets go in, and the expected beats are queued in expected order.
module tb_rdmx_xmit_mux;
   localparam int NCH = 4;
   localparam int DW  = 512;
   localparam int AW  = 64;
   localparam int KW  = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic [16*NCH-1:0] AXIS_PLEN_TDATA;
   logic [NCH-1:0]    AXIS_PLEN_TVALID, AXIS_PLEN_TREADY;
   logic [AW*NCH-1:0] AXIS_ADDR_TDATA;
   logic [NCH-1:0]    AXIS_ADDR_TVALID, AXIS_ADDR_TREADY;
   logic [DW*NCH-1:0] AXIS_DATA_TDATA;
   logic [NCH-1:0]    AXIS_DATA_TLAST, AXIS_DATA_TVALID, AXIS_DATA_TREADY;
   logic [DW-1:0]     AXIS_TX_TDATA;
   logic [KW-1:0]     AXIS_TX_TKEEP;
   logic              AXIS_TX_TLAST, AXIS_TX_TVALID, AXIS_TX_TREADY;
   logic [2:0]        active_ch;

   rdmx_xmit_mux dut (
      .clk(clk), .reset(reset),
      .AXIS_PLEN_TDATA(AXIS_PLEN_TDATA), .AXIS_PLEN_TVALID(AXIS_PLEN_TVALID), .AXIS_PLEN_TREADY(AXIS_PLEN_TREADY),
      .AXIS_ADDR_TDATA(AXIS_ADDR_TDATA), .AXIS_ADDR_TVALID(AXIS_ADDR_TVALID), .AXIS_ADDR_TREADY(AXIS_ADDR_TREADY),
      .AXIS_DATA_TDATA(AXIS_DATA_TDATA), .AXIS_DATA_TLAST(AXIS_DATA_TLAST),
      .AXIS_DATA_TVALID(AXIS_DATA_TVALID), .AXIS_DATA_TREADY(AXIS_DATA_TREADY),
      .AXIS_TX_TDATA(AXIS_TX_TDATA), .AXIS_TX_TKEEP(AXIS_TX_TKEEP), .AXIS_TX_TLAST(AXIS_TX_TLAST),
      .AXIS_TX_TVALID(AXIS_TX_TVALID), .AXIS_TX_TREADY(AXIS_TX_TREADY), .active_ch(active_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [2:0]    ch;
   } beat_t;

   beat_t sb[$];
   int    n_cmp = 0;
   int    n_err = 0;

   // Per-channel source storage: command FIFO and data-beat FIFO, indexed by read and write counters.
   logic [15:0] cmd_plen [NCH][32];
   logic [63:0] cmd_addr [NCH][32];
   logic [DW-1:0] dmem   [NCH][128];
   logic        dlast    [NCH][128];
   int          cmd_wr[NCH], cmd_rd[NCH], dwr[NCH], drd[NCH];
   int          exp_seq[NCH];
   bit          src_en = 1'b0, bp_mode = 1'b0, mon_en = 1'b1, watch3 = 1'b0, dr3_seen = 1'b0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int ch, input int tag, input int beat);
      logic [DW-1:0] r;
      for (int w = 0; w < 16; w++) r[32*w +: 32] = {4'(ch), 12'(tag), 8'(beat), 8'(w)};
      return r;
   endfunction

   task automatic load_pkt(input int ch, input logic [15:0] plen, input logic [63:0] addr, input int tag);
      int nb;
      cmd_plen[ch][cmd_wr[ch]] = plen;
      cmd_addr[ch][cmd_wr[ch]] = addr;
      cmd_wr[ch]++;
      nb = (int'(plen) + 63) / 64;
      for (int b = 0; b < nb; b++) begin
         dmem[ch][dwr[ch]]  = pat(ch, tag, b);
         dlast[ch][dwr[ch]] = (b == nb - 1);
         dwr[ch]++;
      end
   endtask

   // The expected header is built byte by byte. hand_csum != 0 overrides the computed IP checksum.
   task automatic expect_pkt(input int ch, input logic [15:0] plen, input logic [63:0] addr,
                             input int tag, input logic [15:0] hand_csum);
      logic [7:0]    hb [64];
      logic [15:0]   tl, ul, dp, cs;
      logic [31:0]   s;
      logic [31:0]   sq;
      beat_t         bt;
      int            nb;
      tl = plen + 16'd50;
      ul = plen + 16'd30;
      dp = 16'd32002 + 16'(ch);
      for (int i = 0; i < 64; i++) hb[i] = 8'h00;
      for (int i = 0; i < 6; i++) hb[i] = 8'hFF;
      hb[6] = 8'h02; hb[11] = 8'h02; hb[12] = 8'h08; hb[14] = 8'h45;
      hb[16] = tl[15:8]; hb[17] = tl[7:0]; hb[20] = 8'h40; hb[22] = 8'h40; hb[23] = 8'h11;
      hb[26] = 8'd10; hb[27] = 8'd1; hb[28] = 8'd1; hb[29] = 8'd2;
      hb[30] = 8'd10; hb[31] = 8'd1; hb[32] = 8'd1; hb[33] = 8'd255;
      hb[34] = 8'h03; hb[35] = 8'hE8; hb[36] = dp[15:8]; hb[37] = dp[7:0];
      hb[38] = ul[15:8]; hb[39] = ul[7:0]; hb[42] = 8'h01; hb[43] = 8'h22;
      for (int i = 0; i < 8; i++) hb[44+i] = addr[63-8*i -: 8];
`ifdef RDMX_SEQNUM_EN
      sq = 32'(exp_seq[ch]);
`else
      sq = 32'd0;
`endif
      for (int i = 0; i < 4; i++) hb[52+i] = sq[31-8*i -: 8];
      exp_seq[ch]++;
      s = 32'd0;
      for (int i = 14; i < 34; i += 2) s = s + {16'h0000, hb[i], hb[i+1]};
      while (s[31:16] != 16'd0) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
      cs = (hand_csum != 16'd0) ? hand_csum : ~s[15:0];
      hb[24] = cs[15:8]; hb[25] = cs[7:0];
      for (int i = 0; i < 64; i++) bt.data[8*i +: 8] = hb[i];
      bt.keep = {KW{1'b1}};
      bt.last = (plen == 16'd0);
      bt.ch   = 3'(ch);
      sb.push_back(bt);
      nb = (int'(plen) + 63) / 64;
      for (int b = 0; b < nb; b++) begin
         bt.data = pat(ch, tag, b);
         bt.last = (b == nb - 1);
         bt.keep = {KW{1'b1}};
         if (bt.last && (plen[5:0] != 6'd0)) begin
            bt.keep = '0;
            for (int j = 0; j < int'(plen[5:0]); j++) bt.keep[j] = 1'b1;
         end
         sb.push_back(bt);
      end
   endtask

   task automatic wait_drain(input string nm, input int max);
      int c = 0;
      while (sb.size() != 0 && c < max) begin
         @(posedge clk);
         c++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain actual=%0d beats left required=0", nm, sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      for (int k = 0; k < NCH; k++) begin
         cmd_wr[k] = 0; cmd_rd[k] = 0; dwr[k] = 0; drd[k] = 0; exp_seq[k] = 0;
      end
   endtask

   // Source driver: sample handshakes at the falling edge, then advance and redrive just after the rising edge.
   initial begin
      bit pf [NCH];
      bit df [NCH];
      AXIS_PLEN_TDATA = '0; AXIS_PLEN_TVALID = '0; AXIS_ADDR_TDATA = '0; AXIS_ADDR_TVALID = '0;
      AXIS_DATA_TDATA = '0; AXIS_DATA_TLAST = '0; AXIS_DATA_TVALID = '0; AXIS_TX_TREADY = 1'b1;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NCH; k++) begin
            pf[k] = AXIS_PLEN_TVALID[k] && AXIS_PLEN_TREADY[k];
            df[k] = AXIS_DATA_TVALID[k] && AXIS_DATA_TREADY[k];
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < NCH; k++) begin
            if (pf[k] && !reset) cmd_rd[k]++;
            if (df[k] && !reset) drd[k]++;
            AXIS_PLEN_TVALID[k] = src_en && (cmd_rd[k] < cmd_wr[k]);
            AXIS_ADDR_TVALID[k] = src_en && (cmd_rd[k] < cmd_wr[k]);
            AXIS_PLEN_TDATA[16*k +: 16] = AXIS_PLEN_TVALID[k] ? cmd_plen[k][cmd_rd[k]] : 16'd0;
            AXIS_ADDR_TDATA[AW*k +: AW] = AXIS_ADDR_TVALID[k] ? cmd_addr[k][cmd_rd[k]] : 64'd0;
            AXIS_DATA_TVALID[k] = src_en && (drd[k] < dwr[k]);
            AXIS_DATA_TDATA[DW*k +: DW] = AXIS_DATA_TVALID[k] ? dmem[k][drd[k]] : '0;
            AXIS_DATA_TLAST[k] = AXIS_DATA_TVALID[k] ? dlast[k][drd[k]] : 1'b0;
         end
         AXIS_TX_TREADY = bp_mode ? ~AXIS_TX_TREADY : 1'b1;
      end
   end

   // Monitor: every accepted output beat is popped from the scoreboard and compared.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (watch3 && AXIS_DATA_TREADY[3]) dr3_seen = 1'b1;
         if (mon_en && !reset && AXIS_TX_TVALID && AXIS_TX_TREADY) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat actual=beat required=none");
            end else begin
               e = sb.pop_front();
               chk("tdata", AXIS_TX_TDATA, e.data);
               chk("tkeep", DW'(AXIS_TX_TKEEP), DW'(e.keep));
               chk("tlast", DW'(AXIS_TX_TLAST), DW'(e.last));
               chk("active_ch", DW'(active_ch), DW'(e.ch));
            end
         end
      end
   end

   initial begin
      clear_src();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_plen_tready", DW'(AXIS_PLEN_TREADY), '0);
      chk("rst_data_tready", DW'(AXIS_DATA_TREADY), '0);
      chk("rst_tvalid", DW'(AXIS_TX_TVALID), '0);
      chk("rst_tkeep", DW'(AXIS_TX_TKEEP), '0);
      chk("rst_tlast", DW'(AXIS_TX_TLAST), '0);
      chk("rst_active_ch", DW'(active_ch), '0);

      // Arbitration: all four channels are ready at once with the pointer at 0, so grants go 1,2,3,0 twice.
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NCH; k++) load_pkt(k, 16'd64, 64'(k * 16 + r), 10 + r);
      for (int r = 0; r < 2; r++) begin
         expect_pkt(1, 16'd64, 64'(16 + r), 10 + r, 16'h0000);
         expect_pkt(2, 16'd64, 64'(32 + r), 10 + r, 16'h0000);
         expect_pkt(3, 16'd64, 64'(48 + r), 10 + r, 16'h0000);
         expect_pkt(0, 16'd64, 64'(r), 10 + r, 16'h0000);
      end
      @(posedge clk);
      #1 src_en = 1'b1;
      wait_drain("arb", 400);

      // ch0 plen=64: totlen 0x0072, so the hand-computed IP checksum is 0x2379.
      expect_pkt(0, 16'd64, 64'h1122334455667788, 20, 16'h2379);
      load_pkt(0, 16'd64, 64'h1122334455667788, 20);
      wait_drain("ch0_p64", 100);

      // ch2 plen=100: two data beats, and the last keep has 36 low bits set. Checksum 0x2355.
      expect_pkt(2, 16'd100, 64'h0000_0000_DEAD_BEEF, 21, 16'h2355);
      load_pkt(2, 16'd100, 64'h0000_0000_DEAD_BEEF, 21);
      wait_drain("ch2_p100", 100);

      // ch1 plen=256: first run without backpressure, then with TREADY toggling. Frames must match.
      expect_pkt(1, 16'd256, 64'hA5A5_0000_0000_5A5A, 22, 16'h0000);
      load_pkt(1, 16'd256, 64'hA5A5_0000_0000_5A5A, 22);
      wait_drain("ch1_nobp", 100);
      bp_mode = 1'b1;
      expect_pkt(1, 16'd256, 64'hA5A5_0000_0000_5A5A, 22, 16'h0000);
      load_pkt(1, 16'd256, 64'hA5A5_0000_0000_5A5A, 22);
      wait_drain("ch1_bp", 200);
      bp_mode = 1'b0;

      // ch3 plen=0: a lone header beat with TLAST=1, and ch3's data stream is never readied.
      dr3_seen = 1'b0;
      watch3   = 1'b1;
      expect_pkt(3, 16'd0, 64'h0000_0000_0000_0033, 23, 16'h0000);
      load_pkt(3, 16'd0, 64'h0000_0000_0000_0033, 23);
      wait_drain("ch3_p0", 100);
      watch3 = 1'b0;
      chk("ch3_data_tready_seen", DW'(dr3_seen), '0);

      // Reset mid-frame: the packet is abandoned and the outputs return to their reset values.
      mon_en = 1'b0;
      load_pkt(2, 16'd192, 64'h0000_0000_0000_0222, 24);
      begin
         int c = 0;
         while (!AXIS_TX_TVALID && c < 50) begin
            @(posedge clk);
            #1;
            c++;
         end
         n_cmp++;
         if (!AXIS_TX_TVALID) begin
            n_err++;
            $display("FAIL midrst_wait actual=no_tvalid required=tvalid");
         end
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_tvalid", DW'(AXIS_TX_TVALID), '0);
      chk("midrst_tkeep", DW'(AXIS_TX_TKEEP), '0);
      chk("midrst_data_tready", DW'(AXIS_DATA_TREADY), '0);
      chk("midrst_active_ch", DW'(active_ch), '0);
      src_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 clear_src();
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;

      // Sequence test: ch1 x3 and ch0 x1 are loaded together. Pointer 0 gives grant order 1,0,1,1.
      for (int r = 0; r < 3; r++) load_pkt(1, 16'd64, 64'(100 + r), 30 + r);
      load_pkt(0, 16'd64, 64'd200, 40);
      expect_pkt(1, 16'd64, 64'd100, 30, 16'h0000);
      expect_pkt(0, 16'd64, 64'd200, 40, 16'h0000);
      expect_pkt(1, 16'd64, 64'd101, 31, 16'h0000);
      expect_pkt(1, 16'd64, 64'd102, 32, 16'h0000);
      @(posedge clk);
      #1 src_en = 1'b1;
      wait_drain("seq", 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
